tensor_bank_ring: RTL
=====================

# tensor_bank_ring

Parametrised multi-bank tensor buffer for the IMG2COL/GEMM datapath; successor to the two-bank ifmap ping-pong store. Holds NUM_BANKS single-port synchronous RAM banks arranged as a ring. The ring is loaded from DMA, then serves im2col tensor reads from one bank while the GEMM writes results into the next. Banks rotate on every layer boundary, and the final-layer result is drained back to DMA with a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, word width of every bank
- ADDR_SIZE, 10, bank address width; depth = 2**ADDR_SIZE words per bank
- NUM_BANKS, 2, bank count, legal 2..4; 2 gives classic ping-pong
- LCNT_W, 8, width of layer counter
- clk  input  1  system clock; all logic on rising edge
- rstn  input  1  asynchronous active-low reset
- enable  input  1  global run enable (AXI-Lite); 0 freezes FSM, pointers, counter, and all RAM accesses
- conv_en  input  1  one-cycle pulse: layer finished, rotate banks
- w_done  input  1  one-cycle pulse: final layer finished, start drain
- w_addr  input  ADDR_SIZE  DMA load address
- w_data  input  DATA_WIDTH  DMA load data
- w_valid  input  1  DMA load valid
- w_last  input  1  last load beat
- w_ready  output  1  load ready
- r_addr  input  ADDR_SIZE  DMA drain address
- r_valid  input  1  DMA drain request valid
- r_last  input  1  last drain request
- r_ready  output  1  drain ready
- r_data  output  DATA_WIDTH  drain read data
- r_data_vld  output  1  r_data valid strobe
- tensor_addr  input  ADDR_SIZE  im2col read address
- t_addr_vld  input  1  im2col read request
- tensor_data  output  DATA_WIDTH  im2col read data
- tensor_vld  output  1  tensor_data valid strobe
- result_addr  input  ADDR_SIZE  GEMM result write address
- result_data  input  DATA_WIDTH  GEMM result data
- result_w_vld  input  1  result write strobe
- rd_bank  output  clog2(NUM_BANKS)  current source bank index
- layer_cnt  output  LCNT_W  completed-layer count
- state  output  2  FSM state (LOAD=0, COMPUTE=1, DRAIN=2)

## Operation
- Pointers: src = rd_bank; dst = (rd_bank+1) mod NUM_BANKS. src and dst are never equal.
- LOAD (reset state):
  - w_ready = enable.
  - Each beat with w_valid&w_ready writes w_data to bank src at w_addr.
  - w_last on a handshake beat writes that beat, then moves to COMPUTE.
- COMPUTE:
  - t_addr_vld reads bank src at tensor_addr.
  - result_w_vld writes result_data to bank dst at result_addr.
  - conv_en: rd_bank <= dst (wrap NUM_BANKS-1 -> 0); layer_cnt <= layer_cnt+1, wrapping modulo 2**LCNT_W.
  - w_done moves to DRAIN; rd_bank is not rotated, and the result sits in bank dst.
- DRAIN:
  - r_ready = enable.
  - r_valid&r_ready reads bank dst at r_addr.
  - r_last on a handshake moves to LOAD: rd_bank <= 0, layer_cnt <= 0.
- Requests outside their state are ignored: no RAM access and no valid strobe. This covers w_valid outside LOAD, r_valid outside DRAIN, t_addr_vld/result_w_vld outside COMPUTE, and conv_en/w_done outside COMPUTE.
- conv_en and w_done in the same cycle: w_done wins, with no rotation and no count.
- A result write in the same cycle as conv_en commits to the pre-rotation dst bank.
- A tensor read in the same cycle as conv_en returns pre-rotation src data.
- RAMs are inferred behavioural arrays, one port per bank, with per-bank address/enable/write muxes driven by the state and the pointers.

## Timing
- Reset values: state=LOAD, rd_bank=0, layer_cnt=0, r_data=0, tensor_data=0, r_data_vld=0, tensor_vld=0, r_ready=0, w_ready=1 (enable permitting). RAM contents are undefined.
- Write latency: data is in RAM at the clock edge of the request. A read of the same address issued the following cycle returns the new data.
- Read latency is exactly 1 cycle:
  - tensor_vld is asserted in cycle n+1 for a request in cycle n.
  - r_data_vld is asserted in cycle n+1 for a handshake in cycle n.
  - Data is held until the next valid read.
- Full throughput: one access per port per cycle. The tensor read and the result write proceed in parallel.
- State and rd_bank update on the edge following the qualifying pulse. The first access after a transition uses the new mapping.
- enable=0: ready outputs drop combinationally, nothing updates, and valid strobes deassert next cycle.
- Asynchronous reset mid-operation aborts immediately to the reset values. Any in-flight read produces no strobe.

## Test plan
- Reset: assert rstn=0 mid-DRAIN → all outputs at their reset values, state=LOAD, w_ready=1.
- Load then read: load 4 beats (addr 0..3, data 0xA0..0xA3, w_last on beat 3) → state=COMPUTE, w_ready=0. Then tensor reads of addr 0..3 → tensor_data 0xA0..0xA3, each one cycle after its request.
- Ring wrap with NUM_BANKS=3: write 0xB0 to dst addr 5, then conv_en. Repeat with 0xC0 and 0xD0 across the rotations → rd_bank sequence 0→1→2→0, layer_cnt=3. Reading addr 5 returns, in turn, 0xB0 (bank1), 0xC0 (bank2), 0xD0 (bank0).
- Boundary pulses: conv_en and w_done in the same cycle → DRAIN, rd_bank unchanged. A result write coincident with conv_en → lands in the old dst bank.
- Drain: after w_done, read addr 0..7 with r_last on addr 7 → 8 r_data_vld pulses carrying dst contents, then state=LOAD, rd_bank=0, layer_cnt=0.
- Stall: drop enable for 3 cycles during load → w_ready=0, no writes, state and pointers held; load resumes correctly when enable returns.

Source files
------------

// File: rtl/tensor_bank_ring_if.sv
// Bus bundle for tensor_bank_ring: DMA load, DMA drain, im2col read and
// GEMM result write channels. The master drives requests; the slave is the
// bank ring itself.
interface tensor_bank_ring_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 10
);
    // DMA load channel
    logic [ADDR_SIZE-1:0]  w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_ready;
    // DMA drain channel
    logic [ADDR_SIZE-1:0]  r_addr;
    logic                  r_valid;
    logic                  r_last;
    logic                  r_ready;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_data_vld;
    // im2col tensor read channel
    logic [ADDR_SIZE-1:0]  tensor_addr;
    logic                  t_addr_vld;
    logic [DATA_WIDTH-1:0] tensor_data;
    logic                  tensor_vld;
    // GEMM result write channel
    logic [ADDR_SIZE-1:0]  result_addr;
    logic [DATA_WIDTH-1:0] result_data;
    logic                  result_w_vld;

    modport master (
        output w_addr, w_data, w_valid, w_last,
        output r_addr, r_valid, r_last,
        output tensor_addr, t_addr_vld,
        output result_addr, result_data, result_w_vld,
        input  w_ready, r_ready, r_data, r_data_vld, tensor_data, tensor_vld
    );

    modport slave (
        input  w_addr, w_data, w_valid, w_last,
        input  r_addr, r_valid, r_last,
        input  tensor_addr, t_addr_vld,
        input  result_addr, result_data, result_w_vld,
        output w_ready, r_ready, r_data, r_data_vld, tensor_data, tensor_vld
    );
endinterface

// File: rtl/tensor_bank_ring.sv
// Ring of NUM_BANKS single-port RAM banks. Loaded from DMA into the source
// bank, then im2col reads the source bank while GEMM results land in the next
// bank; the ring rotates on every layer boundary and the final result bank is
// drained back to DMA.
module tensor_bank_ring #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 10,
    parameter int NUM_BANKS  = 2,
    parameter int LCNT_W     = 8,
    localparam int BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              conv_en,
    input  logic              w_done,
    tensor_bank_ring_if.slave bus,
    output logic [BANK_W-1:0] rd_bank,
    output logic [LCNT_W-1:0] layer_cnt,
    output logic [1:0]        state
);
    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    state_e              r_state;
    logic [BANK_W-1:0]   r_rd_bank;
    logic [LCNT_W-1:0]   r_layer_cnt;
    logic [BANK_W-1:0]   w_dst;

    logic w_load_hs, w_drain_hs, w_t_rd, w_res_wr;

    // Per-bank port controls and read data
    logic                  w_bank_en    [NUM_BANKS];
    logic                  w_bank_we    [NUM_BANKS];
    logic [ADDR_SIZE-1:0]  w_bank_addr  [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_wdata [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

    // Read-return tracking for the two read channels
    logic                  r_t_pend, r_r_pend;
    logic [BANK_W-1:0]     r_t_sel, r_r_sel;
    logic [DATA_WIDTH-1:0] r_t_hold, r_r_hold;

    // Destination is the bank after the source, wrapping at the end of the ring
    assign w_dst = (r_rd_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : r_rd_bank + 1'b1;

    // Requests only count in their own state and while enabled
    assign w_load_hs  = enable && (r_state == ST_LOAD)    && bus.w_valid;
    assign w_drain_hs = enable && (r_state == ST_DRAIN)   && bus.r_valid;
    assign w_t_rd     = enable && (r_state == ST_COMPUTE) && bus.t_addr_vld;
    assign w_res_wr   = enable && (r_state == ST_COMPUTE) && bus.result_w_vld;

    assign bus.w_ready = enable && (r_state == ST_LOAD);
    assign bus.r_ready = enable && (r_state == ST_DRAIN);

    // Steer each channel onto the bank selected by the current src/dst pointers
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            // NOTE: every output gets a default first so no path leaves a latch.
            w_bank_en[b]    = 1'b0;
            w_bank_we[b]    = 1'b0;
            w_bank_addr[b]  = '0;
            w_bank_wdata[b] = '0;
            if (w_load_hs && r_rd_bank == BANK_W'(b)) begin
                w_bank_en[b]    = 1'b1;
                w_bank_we[b]    = 1'b1;
                w_bank_addr[b]  = bus.w_addr;
                w_bank_wdata[b] = bus.w_data;
            end
            if (w_t_rd && r_rd_bank == BANK_W'(b)) begin
                w_bank_en[b]   = 1'b1;
                w_bank_addr[b] = bus.tensor_addr;
            end
            if (w_res_wr && w_dst == BANK_W'(b)) begin
                w_bank_en[b]    = 1'b1;
                w_bank_we[b]    = 1'b1;
                w_bank_addr[b]  = bus.result_addr;
                w_bank_wdata[b] = bus.result_data;
            end
            if (w_drain_hs && w_dst == BANK_W'(b)) begin
                w_bank_en[b]   = 1'b1;
                w_bank_addr[b] = bus.r_addr;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        logic [DATA_WIDTH-1:0] r_mem [2**ADDR_SIZE];
        logic [DATA_WIDTH-1:0] r_rdata;

        // Single-port synchronous RAM: write or read, one access per cycle
        // NOTE: RAM arrays and their read registers take no reset so they map
        // onto block RAM; their contents after reset are simply undefined.
        always_ff @(posedge clk) begin
            if (w_bank_en[g]) begin
                if (w_bank_we[g]) r_mem[w_bank_addr[g]] <= w_bank_wdata[g];
                else              r_rdata <= r_mem[w_bank_addr[g]];
            end
        end

        assign w_bank_rdata[g] = r_rdata;
    end

    // Layer FSM with bank pointer and layer counter
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rstn) begin
            r_state     <= ST_LOAD;
            r_rd_bank   <= '0;
            r_layer_cnt <= '0;
        end else if (enable) begin
            case (r_state)
                ST_LOAD: begin
                    if (bus.w_valid && bus.w_last) r_state <= ST_COMPUTE;
                end
                ST_COMPUTE: begin
                    if (w_done) begin
                        r_state <= ST_DRAIN;
                    end else if (conv_en) begin
                        r_rd_bank   <= w_dst;
                        r_layer_cnt <= r_layer_cnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (bus.r_valid && bus.r_last) begin
                        r_state     <= ST_LOAD;
                        r_rd_bank   <= '0;
                        r_layer_cnt <= '0;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    // Track which bank returns data next cycle and hold the last returned word
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_t_pend <= 1'b0;
            r_t_sel  <= '0;
            r_t_hold <= '0;
            r_r_pend <= 1'b0;
            r_r_sel  <= '0;
            r_r_hold <= '0;
        end else begin
            r_t_pend <= w_t_rd;
            r_r_pend <= w_drain_hs;
            if (w_t_rd)     r_t_sel <= r_rd_bank;
            if (w_drain_hs) r_r_sel <= w_dst;
            if (r_t_pend)   r_t_hold <= w_bank_rdata[r_t_sel];
            if (r_r_pend)   r_r_hold <= w_bank_rdata[r_r_sel];
        end
    end

    assign bus.tensor_vld  = r_t_pend;
    assign bus.tensor_data = r_t_pend ? w_bank_rdata[r_t_sel] : r_t_hold;
    assign bus.r_data_vld  = r_r_pend;
    assign bus.r_data      = r_r_pend ? w_bank_rdata[r_r_sel] : r_r_hold;

    assign rd_bank   = r_rd_bank;
    assign layer_cnt = r_layer_cnt;
    assign state     = r_state;
endmodule
